// File: rtl/execute_ctrl_pkg.sv
// Shared types for the execute-stage controller:
// forwarding selects, FSM states and scoreboard slots.
package exec_pkg;

  localparam int REG_AW = 3;

  typedef logic [1:0] fwd_t;

  localparam fwd_t FWD_RF    = 2'b00;
  localparam fwd_t FWD_EXMEM = 2'b01;
  localparam fwd_t FWD_MEMWB = 2'b10;

  typedef enum logic [1:0] {
    RUN  = 2'b00,
    LU   = 2'b01,
    HOLD = 2'b10
  } state_t;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              rd_we;
    logic              is_load;
  } slot_t;

  localparam slot_t SLOT_NONE = '0;

endpackage

// File: rtl/execute_ctrl_if.sv
// Decode/execute control bundle between the decode
// stage (master) and the execute controller (slave).
interface execute_ctrl_if;
  import exec_pkg::*;

  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_rd_we;
  logic              id_is_load;
  logic              id_sets_flags;
  logic              mem_busy;
  logic              id_stall;
  logic              pipe_en;
  logic              ex_valid;
  fwd_t              ex_fwd_a;
  fwd_t              ex_fwd_b;
  logic              ex_flags_we;

  modport master (
    output id_valid, id_rs1, id_rs2,
    output id_use_rs1, id_use_rs2,
    output id_rd, id_rd_we, id_is_load,
    output id_sets_flags, mem_busy,
    input  id_stall, pipe_en, ex_valid,
    input  ex_fwd_a, ex_fwd_b, ex_flags_we
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2,
    input  id_use_rs1, id_use_rs2,
    input  id_rd, id_rd_we, id_is_load,
    input  id_sets_flags, mem_busy,
    output id_stall, pipe_en, ex_valid,
    output ex_fwd_a, ex_fwd_b, ex_flags_we
  );

endinterface

// File: rtl/execute_ctrl_fwd_select.sv
// Per-operand forwarding priority: the nearest
// producer wins; unused sources read the register file.
module fwd_select
  import exec_pkg::*;
(
  input  logic              en,
  input  logic [REG_AW-1:0] rs,
  input  slot_t             ex,
  input  logic              mem_valid,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_rd_we,
  output fwd_t              sel
);

  logic ex_hit;
  logic mem_hit;

  // A load in EX never forwards; the hazard logic stalls instead.
  assign ex_hit = ex.valid & ex.rd_we
                & (ex.rd == rs) & !ex.is_load;
  assign mem_hit = mem_valid & mem_rd_we
                 & (mem_rd == rs);

  always_comb begin
    sel = FWD_RF;
    unique case (1'b1)
      (en & ex_hit):            sel = FWD_EXMEM;
      (en & !ex_hit & mem_hit): sel = FWD_MEMWB;
      default:                  sel = FWD_RF;
    endcase
  end

endmodule

// File: rtl/execute_ctrl.sv
// Execute-stage issue, hazard and forwarding control:
// scoreboard of in-flight writers, load-use bubbles, flag gating.
module execute_ctrl
  import exec_pkg::*;
(
  input logic           clk,
  input logic           rst,
  execute_ctrl_if.slave bus
);

  slot_t  s_ex;
  slot_t  s_mem;
  slot_t  s_wb;
  logic   ex_sets_flags;
  fwd_t   fwd_a;
  fwd_t   fwd_b;
  fwd_t   nxt_a;
  fwd_t   nxt_b;
  state_t state;
  logic   lu;
  logic   accept;
  logic   unused;

  assign lu = bus.id_valid & s_ex.valid
            & s_ex.is_load & s_ex.rd_we
            & ((bus.id_use_rs1 & (bus.id_rs1 == s_ex.rd))
             | (bus.id_use_rs2 & (bus.id_rs2 == s_ex.rd)));

  assign bus.pipe_en  = !bus.mem_busy;
  assign bus.id_stall = !rst & (bus.mem_busy | lu);
  assign accept       = bus.id_valid & !bus.id_stall;

  fwd_select u_fwd_a (
    .en        (bus.id_use_rs1),
    .rs        (bus.id_rs1),
    .ex        (s_ex),
    .mem_valid (s_mem.valid),
    .mem_rd    (s_mem.rd),
    .mem_rd_we (s_mem.rd_we),
    .sel       (nxt_a)
  );

  fwd_select u_fwd_b (
    .en        (bus.id_use_rs2),
    .rs        (bus.id_rs2),
    .ex        (s_ex),
    .mem_valid (s_mem.valid),
    .mem_rd    (s_mem.rd),
    .mem_rd_we (s_mem.rd_we),
    .sel       (nxt_b)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_ex          <= SLOT_NONE;
      s_mem         <= SLOT_NONE;
      s_wb          <= SLOT_NONE;
      ex_sets_flags <= 1'b0;
      fwd_a         <= FWD_RF;
      fwd_b         <= FWD_RF;
      state         <= RUN;
    end else begin
      if (bus.pipe_en) begin
        s_wb  <= s_mem;
        s_mem <= s_ex;
        if (accept) begin
          s_ex <= '{1'b1, bus.id_rd,
                    bus.id_rd_we, bus.id_is_load};
          ex_sets_flags <= bus.id_sets_flags;
          fwd_a         <= nxt_a;
          fwd_b         <= nxt_b;
        end else begin
          s_ex          <= SLOT_NONE;
          ex_sets_flags <= 1'b0;
          fwd_a         <= FWD_RF;
          fwd_b         <= FWD_RF;
        end
      end
      unique case (state)
        RUN: begin
          if (bus.mem_busy)  state <= HOLD;
          else if (lu)       state <= LU;
        end
        LU: begin
          if (bus.mem_busy)  state <= HOLD;
          else               state <= RUN;
        end
        HOLD: begin
          if (!bus.mem_busy) state <= RUN;
        end
        default:             state <= RUN;
      endcase
    end
  end

  assign bus.ex_valid    = s_ex.valid;
  assign bus.ex_fwd_a    = fwd_a;
  assign bus.ex_fwd_b    = fwd_b;
  assign bus.ex_flags_we = s_ex.valid & ex_sets_flags
                         & bus.pipe_en;

  // MEM/WB writers are served by the write-before-read register file.
  assign unused = ^{s_wb};

endmodule

// File: tb/tb_execute_ctrl.sv
// Directed bench for execute_ctrl: forwarding,
// load-use bubbles, memory freeze, flag gating, reset.
module tb_execute_ctrl;

  logic clk;
  logic rst;
  int   cmp;
  int   bad;

  execute_ctrl_if bus ();

  execute_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired, required finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.id_valid      = 1'b0;
    bus.id_rs1        = '0;
    bus.id_rs2        = '0;
    bus.id_use_rs1    = 1'b0;
    bus.id_use_rs2    = 1'b0;
    bus.id_rd         = '0;
    bus.id_rd_we      = 1'b0;
    bus.id_is_load    = 1'b0;
    bus.id_sets_flags = 1'b0;
  endtask

  task automatic drive_instr(
    input logic [2:0] rd,
    input logic [2:0] rs1,
    input logic [2:0] rs2,
    input logic u1, input logic u2,
    input logic we, input logic ld,
    input logic fl
  );
    bus.id_valid      = 1'b1;
    bus.id_rd         = rd;
    bus.id_rs1        = rs1;
    bus.id_rs2        = rs2;
    bus.id_use_rs1    = u1;
    bus.id_use_rs2    = u2;
    bus.id_rd_we      = we;
    bus.id_is_load    = ld;
    bus.id_sets_flags = fl;
  endtask

  task automatic flush();
    drive_idle();
    bus.mem_busy = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.mem_busy = 1'b0;
    drive_idle();
    #3;
    cmp++;
    if ({bus.ex_valid, bus.ex_fwd_a, bus.ex_fwd_b,
         bus.ex_flags_we, bus.id_stall, bus.pipe_en}
        !== 7'b0_00_00_0_0_1) begin
      bad++;
      $display("FAIL reset_outs: got %b required 0000001",
        {bus.ex_valid, bus.ex_fwd_a, bus.ex_fwd_b,
         bus.ex_flags_we, bus.id_stall, bus.pipe_en});
    end
    bus.mem_busy = 1'b1;
    #1;
    cmp++;
    if ({bus.id_stall, bus.pipe_en} !== 2'b00) begin
      bad++;
      $display("FAIL reset_busy: stall/pipe_en %b required 00",
        {bus.id_stall, bus.pipe_en});
    end
    bus.mem_busy = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  task automatic test_fwd_exmem();
    drive_instr(3'd1, 3'd6, 3'd7, 1, 1, 1, 0, 0);
    step();
    drive_instr(3'd2, 3'd1, 3'd3, 1, 1, 1, 0, 0);
    @(negedge clk);
    cmp++;
    if (bus.id_stall !== 1'b0) begin
      bad++;
      $display("FAIL exmem_stall: got %b required 0", bus.id_stall);
    end
    step();
    drive_idle();
    @(negedge clk);
    cmp++;
    if ({bus.ex_valid, bus.ex_fwd_a, bus.ex_fwd_b} !== 5'b1_01_00) begin
      bad++;
      $display("FAIL exmem_fwd: got %b required 10100",
        {bus.ex_valid, bus.ex_fwd_a, bus.ex_fwd_b});
    end
    flush();
  endtask

  task automatic test_fwd_memwb();
    drive_instr(3'd1, 3'd6, 3'd7, 1, 1, 1, 0, 0);
    step();
    drive_idle();
    step();
    drive_instr(3'd4, 3'd5, 3'd1, 1, 1, 1, 0, 0);
    step();
    drive_idle();
    @(negedge clk);
    cmp++;
    if ({bus.ex_valid, bus.ex_fwd_a, bus.ex_fwd_b} !== 5'b1_00_10) begin
      bad++;
      $display("FAIL memwb_fwd: got %b required 10010",
        {bus.ex_valid, bus.ex_fwd_a, bus.ex_fwd_b});
    end
    flush();
    drive_instr(3'd1, 3'd6, 3'd7, 1, 1, 1, 0, 0);
    step();
    drive_idle();
    repeat (2) step();
    drive_instr(3'd4, 3'd5, 3'd1, 1, 1, 1, 0, 0);
    step();
    drive_idle();
    @(negedge clk);
    cmp++;
    if ({bus.ex_valid, bus.ex_fwd_a, bus.ex_fwd_b} !== 5'b1_00_00) begin
      bad++;
      $display("FAIL rf_fwd: got %b required 10000",
        {bus.ex_valid, bus.ex_fwd_a, bus.ex_fwd_b});
    end
    flush();
  endtask

  task automatic test_load_use();
    drive_instr(3'd2, 3'd1, 3'd0, 1, 0, 1, 1, 0);
    step();
    drive_instr(3'd3, 3'd2, 3'd2, 1, 1, 1, 0, 0);
    @(negedge clk);
    cmp++;
    if (bus.id_stall !== 1'b1) begin
      bad++;
      $display("FAIL lu_stall: got %b required 1", bus.id_stall);
    end
    step();
    @(negedge clk);
    cmp++;
    if ({bus.id_stall, bus.ex_valid} !== 2'b00) begin
      bad++;
      $display("FAIL lu_bubble: stall/ex_valid %b required 00",
        {bus.id_stall, bus.ex_valid});
    end
    step();
    drive_idle();
    @(negedge clk);
    cmp++;
    if ({bus.ex_valid, bus.ex_fwd_a, bus.ex_fwd_b} !== 5'b1_10_10) begin
      bad++;
      $display("FAIL lu_fwd: got %b required 11010",
        {bus.ex_valid, bus.ex_fwd_a, bus.ex_fwd_b});
    end
    flush();
  endtask

  task automatic test_load_use_busy();
    int stalls;
    int frozen;
    logic exp_stall;
    logic exp_pe;
    stalls = 0;
    frozen = 0;
    drive_instr(3'd2, 3'd1, 3'd0, 1, 0, 1, 1, 0);
    step();
    drive_instr(3'd3, 3'd2, 3'd2, 1, 1, 1, 0, 0);
    bus.mem_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      exp_stall = (i < 4);
      exp_pe    = (i >= 3);
      if (bus.id_stall === 1'b1) stalls++;
      if (bus.pipe_en === 1'b0) frozen++;
      cmp++;
      if ({bus.id_stall, bus.pipe_en, bus.ex_flags_we}
          !== {exp_stall, exp_pe, 1'b0}) begin
        bad++;
        $display("FAIL busy_cycle%0d: stall/pe/flags %b required %b",
          i, {bus.id_stall, bus.pipe_en, bus.ex_flags_we},
          {exp_stall, exp_pe, 1'b0});
      end
      step();
      if (i == 2) bus.mem_busy = 1'b0;
      if (i == 4) drive_idle();
    end
    cmp++;
    if (stalls !== 4 || frozen !== 3) begin
      bad++;
      $display("FAIL busy_counts: stalls %0d frozen %0d required 4 3",
        stalls, frozen);
    end
    @(negedge clk);
    cmp++;
    if ({bus.ex_valid, bus.ex_fwd_a, bus.ex_fwd_b,
         bus.ex_flags_we} !== 6'b1_10_10_0) begin
      bad++;
      $display("FAIL busy_fwd: got %b required 110100",
        {bus.ex_valid, bus.ex_fwd_a, bus.ex_fwd_b, bus.ex_flags_we});
    end
    flush();
  endtask

  task automatic test_back_to_back_loads();
    drive_instr(3'd2, 3'd1, 3'd0, 1, 0, 1, 1, 0);
    step();
    drive_instr(3'd2, 3'd1, 3'd0, 1, 0, 1, 1, 0);
    @(negedge clk);
    cmp++;
    if (bus.id_stall !== 1'b0) begin
      bad++;
      $display("FAIL ld2_stall: got %b required 0", bus.id_stall);
    end
    step();
    drive_instr(3'd3, 3'd2, 3'd4, 1, 1, 1, 0, 0);
    @(negedge clk);
    cmp++;
    if (bus.id_stall !== 1'b1) begin
      bad++;
      $display("FAIL ld2_lu: got %b required 1", bus.id_stall);
    end
    step();
    @(negedge clk);
    cmp++;
    if (bus.id_stall !== 1'b0) begin
      bad++;
      $display("FAIL ld2_once: got %b required 0", bus.id_stall);
    end
    step();
    drive_idle();
    @(negedge clk);
    cmp++;
    if ({bus.ex_valid, bus.ex_fwd_a, bus.ex_fwd_b} !== 5'b1_10_00) begin
      bad++;
      $display("FAIL ld2_fwd: got %b required 11000",
        {bus.ex_valid, bus.ex_fwd_a, bus.ex_fwd_b});
    end
    flush();
  endtask

  task automatic test_flags_once();
    int writes;
    logic exp_we;
    writes = 0;
    drive_instr(3'd0, 3'd1, 3'd2, 1, 1, 0, 0, 1);
    step();
    drive_idle();
    bus.mem_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      exp_we = (i == 2);
      if (bus.ex_flags_we === 1'b1) writes++;
      cmp++;
      if (bus.ex_flags_we !== exp_we) begin
        bad++;
        $display("FAIL flags_cycle%0d: got %b required %b",
          i, bus.ex_flags_we, exp_we);
      end
      step();
      if (i == 1) bus.mem_busy = 1'b0;
    end
    cmp++;
    if (writes !== 1) begin
      bad++;
      $display("FAIL flags_count: got %0d required 1", writes);
    end
    flush();
  endtask

  task automatic test_reset_mid();
    drive_instr(3'd2, 3'd1, 3'd0, 1, 0, 1, 1, 0);
    step();
    drive_instr(3'd4, 3'd1, 3'd1, 1, 1, 1, 0, 1);
    step();
    drive_instr(3'd5, 3'd2, 3'd4, 1, 1, 1, 0, 0);
    #2;
    cmp++;
    if ({bus.ex_valid, bus.ex_flags_we} !== 2'b11) begin
      bad++;
      $display("FAIL rstmid_pre: valid/flags %b required 11",
        {bus.ex_valid, bus.ex_flags_we});
    end
    rst = 1'b1;
    #1;
    cmp++;
    if ({bus.ex_valid, bus.ex_fwd_a, bus.ex_fwd_b,
         bus.ex_flags_we, bus.id_stall, bus.pipe_en}
        !== 7'b0_00_00_0_0_1) begin
      bad++;
      $display("FAIL rstmid_outs: got %b required 0000001",
        {bus.ex_valid, bus.ex_fwd_a, bus.ex_fwd_b,
         bus.ex_flags_we, bus.id_stall, bus.pipe_en});
    end
    drive_idle();
    @(negedge clk);
    rst = 1'b0;
    step();
    drive_instr(3'd5, 3'd2, 3'd4, 1, 1, 1, 0, 0);
    step();
    drive_idle();
    @(negedge clk);
    cmp++;
    if ({bus.ex_valid, bus.ex_fwd_a, bus.ex_fwd_b} !== 5'b1_00_00) begin
      bad++;
      $display("FAIL rstmid_fwd: got %b required 10000",
        {bus.ex_valid, bus.ex_fwd_a, bus.ex_fwd_b});
    end
    flush();
  endtask

  initial begin
    cmp = 0;
    bad = 0;
    test_reset();
    test_fwd_exmem();
    test_fwd_memwb();
    test_load_use();
    test_load_use_busy();
    test_back_to_back_loads();
    test_flags_once();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

endmodule
